// File: rtl/pmem_pkg.sv
// Shared types and helpers for the pmem responder: FSM state encoding, word/strobe
// widths and the address-window decode.
package pmem_pkg;

    localparam int WORD_W = 32;
    localparam int STRB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic        in_range;
        logic [31:0] index;
    } addr_chk_t;

    // The subtraction may wrap below base; the explicit addr>=base term catches that case.
    function automatic addr_chk_t addr_check(input logic [31:0] addr,
                                             input logic [31:0] base,
                                             input logic [31:0] depth);
        addr_chk_t   chk;
        logic [31:0] off;
        off          = addr - base;
        chk.index    = {2'b00, off[31:2]};
        chk.in_range = (addr >= base) && (chk.index < depth);
        return chk;
    endfunction

endpackage

// File: rtl/pmem_responder_if.sv
// Request/response bus between the core data-memory port (master) and the
// pmem responder (slave).
interface pmem_responder_if #(
    parameter int unsigned ADDR_W = 32
);
    import pmem_pkg::*;

    logic                req_valid;
    logic                req_ready;
    logic                req_we;
    logic [ADDR_W-1:0]   req_addr;
    logic [WORD_W-1:0]   req_wdata;
    logic [STRB_W-1:0]   req_wmask;
    logic                resp_valid;
    logic                resp_ready;
    logic [WORD_W-1:0]   resp_rdata;
    logic                resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wmask, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wmask, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/pmem_array.sv
// Single-port word array with per-byte write enables and a registered read port.
// The read register doubles as the response data register, so it can be cleared.
module pmem_array
    import pmem_pkg::*;
#(
    parameter  int unsigned DEPTH_WORDS = 1024,
    localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              we,
    input  logic              clr,
    input  logic [IDX_W-1:0]  idx,
    input  logic [WORD_W-1:0] wdata,
    input  logic [STRB_W-1:0] wmask,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_r [DEPTH_WORDS];
    logic [WORD_W-1:0] rdata_r;

    // Byte-strobed write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wmask[b]) begin
                    mem_r[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Read data register, zeroed on reset and when the response is retired.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= {WORD_W{1'b0}};
        end else if (en && !we) begin
            rdata_r <= mem_r[idx];
        end else if (clr) begin
            rdata_r <= {WORD_W{1'b0}};
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/pmem_responder.sv
// Single-outstanding memory responder for the core data port, backed by pmem_array.
// Define MEM_TRACE_EN to print every performed write, read and out-of-range access.
module pmem_responder
    import pmem_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       DEPTH_WORDS = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned       LATENCY     = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    pmem_responder_if.slave bus
);

    localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

    state_t              state_r, state_nxt_s;
    logic [3:0]          cnt_r, cnt_nxt_s;
    logic                resp_valid_r, resp_valid_nxt_s;
    logic                resp_err_r, resp_err_nxt_s;
    logic                accept_s, access_s, retire_s, clr_s;
    logic                we_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [WORD_W-1:0]   wdata_r;
    logic [STRB_W-1:0]   wmask_r;
    logic [WORD_W-1:0]   rdata_s;
    addr_chk_t           chk_s;
    logic                unused_bits_s;

    assign chk_s         = addr_check(32'(addr_r), 32'(BASE_ADDR), 32'(DEPTH_WORDS));
    assign unused_bits_s = ^{chk_s.index[31:IDX_W], bus.req_addr[1:0]};

    // Next-state, counter and response-flag logic.
    always_comb begin
        state_nxt_s      = state_r;
        cnt_nxt_s        = cnt_r;
        resp_valid_nxt_s = resp_valid_r;
        resp_err_nxt_s   = resp_err_r;
        accept_s         = 1'b0;
        access_s         = 1'b0;
        retire_s         = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.req_valid) begin
                    accept_s    = 1'b1;
                    cnt_nxt_s   = CNT_LOAD;
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 4'd0) begin
                    access_s         = 1'b1;
                    resp_valid_nxt_s = 1'b1;
                    resp_err_nxt_s   = ~chk_s.in_range;
                    state_nxt_s      = RESP;
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    retire_s         = 1'b1;
                    resp_valid_nxt_s = 1'b0;
                    resp_err_nxt_s   = 1'b0;
                    state_nxt_s      = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                resp_valid_nxt_s = 1'b0;
                resp_err_nxt_s   = 1'b0;
                state_nxt_s      = IDLE;
            end
        endcase
    end

    // FSM, latency counter and response flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            cnt_r        <= 4'd0;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            resp_valid_r <= resp_valid_nxt_s;
            resp_err_r   <= resp_err_nxt_s;
        end
    end

    // Request capture; the address is forced word-aligned on the way in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_r    <= 1'b0;
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= {WORD_W{1'b0}};
            wmask_r <= {STRB_W{1'b0}};
        end else if (accept_s) begin
            we_r    <= bus.req_we;
            addr_r  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
            wdata_r <= bus.req_wdata;
            wmask_r <= bus.req_wmask;
        end else begin
            we_r    <= we_r;
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
            wmask_r <= wmask_r;
        end
    end

    assign clr_s = retire_s || (access_s && (we_r || !chk_s.in_range));

    pmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (access_s && chk_s.in_range),
        .we    (we_r),
        .clr   (clr_s),
        .idx   (chk_s.index[IDX_W-1:0]),
        .wdata (wdata_r),
        .wmask (wmask_r),
        .rdata (rdata_s)
    );

    assign bus.req_ready  = rst_n & (state_r == IDLE);
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_err   = resp_err_r;
    assign bus.resp_rdata = rdata_s;

`ifdef MEM_TRACE_EN
    logic trace_rd_r;
    // Reads are reported one cycle after the access, once the read register holds the word.
    always @(posedge clk) begin
        if (access_s && chk_s.in_range && we_r)
            $display("PMEM WR addr=%h data=%h mask=%b", addr_r, wdata_r, wmask_r);
        if (access_s && !chk_s.in_range)
            $display("PMEM ERR addr=%h we=%b", addr_r, we_r);
        if (trace_rd_r)
            $display("PMEM RD addr=%h data=%h", addr_r, rdata_s);
        trace_rd_r <= access_s && chk_s.in_range && !we_r;
    end
`endif

endmodule

// File: tb/tb_pmem_responder.sv
// Directed bench for pmem_responder: one LATENCY=1 and one LATENCY=4 instance,
// with hand-computed expectations and a small word model for the long run.
module tb_pmem_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    pmem_responder_if #(.ADDR_W(32)) if1 ();
    pmem_responder_if #(.ADDR_W(32)) if4 ();

    pmem_responder #(.ADDR_W(32), .DEPTH_WORDS(1024), .BASE_ADDR(32'h8000_0000), .LATENCY(1))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    pmem_responder #(.ADDR_W(32), .DEPTH_WORDS(1024), .BASE_ADDR(32'h8000_0000), .LATENCY(4))
        dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

    // One transaction on the LATENCY=1 instance; reports data, error, latency and handshake health.
    task automatic txn1(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] mask, input int stall,
                        output logic [31:0] rdata, output logic err, output int lat, output bit hold_ok);
        @(negedge clk);
        hold_ok = (if1.req_ready === 1'b1);
        if1.req_valid = 1'b1; if1.req_we = we; if1.req_addr = addr;
        if1.req_wdata = wdata; if1.req_wmask = mask;
        @(negedge clk);
        if1.req_valid = 1'b0; if1.req_we = ~we; if1.req_addr = $urandom();
        if1.req_wdata = $urandom(); if1.req_wmask = 4'hF;
        lat = 0;
        while (!if1.resp_valid && lat < 20) begin
            if (if1.req_ready !== 1'b0) hold_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        rdata = if1.resp_rdata; err = if1.resp_err;
        if (if1.req_ready !== 1'b0) hold_ok = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (if1.resp_valid !== 1'b1 || if1.resp_rdata !== rdata || if1.resp_err !== err
                || if1.req_ready !== 1'b0) hold_ok = 1'b0;
        end
        if1.resp_ready = 1'b1;
        @(negedge clk);
        if1.resp_ready = 1'b0;
        if (if1.resp_valid !== 1'b0 || if1.req_ready !== 1'b1) hold_ok = 1'b0;
    endtask

    // Same transaction sequence on the LATENCY=4 instance.
    task automatic txn4(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] mask, input int stall,
                        output logic [31:0] rdata, output logic err, output int lat, output bit hold_ok);
        @(negedge clk);
        hold_ok = (if4.req_ready === 1'b1);
        if4.req_valid = 1'b1; if4.req_we = we; if4.req_addr = addr;
        if4.req_wdata = wdata; if4.req_wmask = mask;
        @(negedge clk);
        if4.req_valid = 1'b0; if4.req_we = ~we; if4.req_addr = $urandom();
        if4.req_wdata = $urandom(); if4.req_wmask = 4'hF;
        lat = 0;
        while (!if4.resp_valid && lat < 20) begin
            if (if4.req_ready !== 1'b0) hold_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        rdata = if4.resp_rdata; err = if4.resp_err;
        if (if4.req_ready !== 1'b0) hold_ok = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (if4.resp_valid !== 1'b1 || if4.resp_rdata !== rdata || if4.resp_err !== err
                || if4.req_ready !== 1'b0) hold_ok = 1'b0;
        end
        if4.resp_ready = 1'b1;
        @(negedge clk);
        if4.resp_ready = 1'b0;
        if (if4.resp_valid !== 1'b0 || if4.req_ready !== 1'b1) hold_ok = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        n_checks++;
        if (if1.req_ready !== 1'b0 || if4.req_ready !== 1'b0 || if1.resp_valid !== 1'b0
            || if4.resp_valid !== 1'b0)
            $display("FAIL reset_low: ready=%b/%b valid=%b/%b, required 0/0 0/0",
                     if1.req_ready, if4.req_ready, if1.resp_valid, if4.resp_valid);
        else n_pass++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (if1.req_ready !== 1'b1 || if4.req_ready !== 1'b1 || if1.resp_valid !== 1'b0
            || if1.resp_rdata !== 32'h0 || if1.resp_err !== 1'b0 || if4.resp_rdata !== 32'h0)
            $display("FAIL reset_release: ready=%b/%b valid=%b rdata=%h err=%b, required 1/1 0 0 0",
                     if1.req_ready, if4.req_ready, if1.resp_valid, if1.resp_rdata, if1.resp_err);
        else n_pass++;
    endtask

    task automatic test_full_write;
        logic [31:0] rd; logic er; int lat; bit ok;
        txn1(1'b1, 32'h8000_0000, 32'hDEAD_BEEF, 4'b1111, 0, rd, er, lat, ok);
        n_checks++;
        if (lat !== 1 || er !== 1'b0 || rd !== 32'h0 || !ok)
            $display("FAIL full_write: lat=%0d err=%b rdata=%h ok=%0d, required 1 0 00000000 1", lat, er, rd, ok);
        else n_pass++;
        txn1(1'b0, 32'h8000_0000, 32'h0, 4'b0000, 1, rd, er, lat, ok);
        n_checks++;
        if (rd !== 32'hDEAD_BEEF || er !== 1'b0 || lat !== 1 || !ok)
            $display("FAIL raw_read: rdata=%h err=%b lat=%0d ok=%0d, required deadbeef 0 1 1", rd, er, lat, ok);
        else n_pass++;
    endtask

    task automatic test_partial_write;
        logic [31:0] rd; logic er; int lat; bit ok;
        txn1(1'b1, 32'h8000_0004, 32'h1122_3344, 4'b1111, 0, rd, er, lat, ok);
        txn1(1'b1, 32'h8000_0006, 32'h0000_AB00, 4'b0010, 0, rd, er, lat, ok);
        n_checks++;
        if (rd !== 32'h0 || er !== 1'b0 || !ok)
            $display("FAIL partial_write_resp: rdata=%h err=%b ok=%0d, required 0 0 1", rd, er, ok);
        else n_pass++;
        txn1(1'b1, 32'h8000_0005, 32'hFFFF_FFFF, 4'b0000, 0, rd, er, lat, ok);
        n_checks++;
        if (rd !== 32'h0 || er !== 1'b0 || lat !== 1)
            $display("FAIL nomask_write_resp: rdata=%h err=%b lat=%0d, required 0 0 1", rd, er, lat);
        else n_pass++;
        txn1(1'b0, 32'h8000_0007, 32'h0, 4'b0000, 0, rd, er, lat, ok);
        n_checks++;
        if (rd !== 32'h1122_AB44 || er !== 1'b0)
            $display("FAIL partial_read: rdata=%h err=%b, required 1122ab44 0", rd, er);
        else n_pass++;
    endtask

    task automatic test_out_of_range;
        logic [31:0] rd; logic er; int lat; bit ok;
        txn1(1'b1, 32'h8000_0FFC, 32'h0BAD_F00D, 4'b1111, 0, rd, er, lat, ok);
        txn1(1'b0, 32'h7FFF_FFFC, 32'h0, 4'b0000, 2, rd, er, lat, ok);
        n_checks++;
        if (rd !== 32'h0 || er !== 1'b1 || !ok)
            $display("FAIL oor_read_low: rdata=%h err=%b ok=%0d, required 0 1 1", rd, er, ok);
        else n_pass++;
        txn1(1'b0, 32'h8000_1000, 32'h0, 4'b0000, 0, rd, er, lat, ok);
        n_checks++;
        if (rd !== 32'h0 || er !== 1'b1)
            $display("FAIL oor_read_high: rdata=%h err=%b, required 0 1", rd, er);
        else n_pass++;
        txn1(1'b1, 32'h8000_1000, 32'h5555_5555, 4'b1111, 0, rd, er, lat, ok);
        n_checks++;
        if (rd !== 32'h0 || er !== 1'b1)
            $display("FAIL oor_write_high: rdata=%h err=%b, required 0 1", rd, er);
        else n_pass++;
        txn1(1'b1, 32'h7FFF_FFFC, 32'h6666_6666, 4'b1111, 0, rd, er, lat, ok);
        n_checks++;
        if (er !== 1'b1)
            $display("FAIL oor_write_low: err=%b, required 1", er);
        else n_pass++;
        txn1(1'b0, 32'h8000_0000, 32'h0, 4'b0000, 0, rd, er, lat, ok);
        n_checks++;
        if (rd !== 32'hDEAD_BEEF || er !== 1'b0)
            $display("FAIL oor_word0_intact: rdata=%h err=%b, required deadbeef 0", rd, er);
        else n_pass++;
        txn1(1'b0, 32'h8000_0FFC, 32'h0, 4'b0000, 0, rd, er, lat, ok);
        n_checks++;
        if (rd !== 32'h0BAD_F00D || er !== 1'b0)
            $display("FAIL oor_last_intact: rdata=%h err=%b, required 0badf00d 0", rd, er);
        else n_pass++;
    endtask

    task automatic test_latency4;
        logic [31:0] rd; logic er; int lat; bit ok;
        txn4(1'b1, 32'h8000_0020, 32'hA5A5_5A5A, 4'b1111, 0, rd, er, lat, ok);
        n_checks++;
        if (lat !== 4 || er !== 1'b0 || rd !== 32'h0 || !ok)
            $display("FAIL lat4_write: lat=%0d err=%b rdata=%h ok=%0d, required 4 0 0 1", lat, er, rd, ok);
        else n_pass++;
        txn4(1'b0, 32'h8000_0020, 32'h0, 4'b0000, 3, rd, er, lat, ok);
        n_checks++;
        if (lat !== 4 || er !== 1'b0 || rd !== 32'hA5A5_5A5A || !ok)
            $display("FAIL lat4_stall_read: lat=%0d err=%b rdata=%h ok=%0d, required 4 0 a5a55a5a 1", lat, er, rd, ok);
        else n_pass++;
    endtask

    task automatic test_reset_mid_txn;
        logic [31:0] rd; logic er; int lat; bit ok; bit seen;
        txn1(1'b1, 32'h8000_0010, 32'hCAFE_F00D, 4'b1111, 0, rd, er, lat, ok);
        @(negedge clk);
        if1.req_valid = 1'b1; if1.req_we = 1'b1; if1.req_addr = 32'h8000_0010;
        if1.req_wdata = 32'h1234_5678; if1.req_wmask = 4'b1111;
        @(negedge clk);
        if1.req_valid = 1'b0;
        rst_n = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (if1.resp_valid !== 1'b0) seen = 1'b1;
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (if1.resp_valid !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen || if1.req_ready !== 1'b1)
            $display("FAIL reset_drop: resp_seen=%0d req_ready=%b, required 0 1", seen, if1.req_ready);
        else n_pass++;
        txn1(1'b0, 32'h8000_0010, 32'h0, 4'b0000, 0, rd, er, lat, ok);
        n_checks++;
        if (rd !== 32'hCAFE_F00D || er !== 1'b0)
            $display("FAIL reset_write_dropped: rdata=%h err=%b, required cafef00d 0", rd, er);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [31:0] model [16];
        logic [31:0] rd, wd, exp_rd; logic er, exp_er; int lat; bit ok;
        logic [3:0]  m; int w; logic [31:0] a;
        for (int i = 0; i < 16; i++) begin
            model[i] = $urandom();
            txn1(1'b1, 32'h8000_0080 + 32'(4 * i), model[i], 4'b1111, 0, rd, er, lat, ok);
            n_checks++;
            if (er !== 1'b0 || rd !== 32'h0 || lat !== 1 || !ok)
                $display("FAIL b2b_init[%0d]: err=%b rdata=%h lat=%0d ok=%0d, required 0 0 1 1", i, er, rd, lat, ok);
            else n_pass++;
        end
        for (int t = 0; t < 200; t++) begin
            w  = int'($urandom_range(15, 0));
            a  = 32'h8000_0080 + 32'(4 * w) + 32'($urandom_range(3, 0));
            wd = $urandom();
            m  = 4'($urandom_range(15, 0));
            exp_er = 1'b0;
            exp_rd = 32'h0;
            if (t % 17 == 5) begin
                a = 32'h8000_1000 + 32'(4 * w);
                exp_er = 1'b1;
            end else if (t % 2 == 1) begin
                exp_rd = model[w];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (m[b]) model[w][8*b +: 8] = wd[8*b +: 8];
            end
            txn1(t % 2 == 0, a, wd, m, int'($urandom_range(3, 0)), rd, er, lat, ok);
            n_checks++;
            if (rd !== exp_rd || er !== exp_er || lat !== 1 || !ok)
                $display("FAIL b2b[%0d]: addr=%h rdata=%h err=%b lat=%0d ok=%0d, required %h %b 1 1",
                         t, a, rd, er, lat, ok, exp_rd, exp_er);
            else n_pass++;
        end
    endtask

    initial begin
        if1.req_valid = 1'b0; if1.req_we = 1'b0; if1.req_addr = 32'h0;
        if1.req_wdata = 32'h0; if1.req_wmask = 4'h0; if1.resp_ready = 1'b0;
        if4.req_valid = 1'b0; if4.req_we = 1'b0; if4.req_addr = 32'h0;
        if4.req_wdata = 32'h0; if4.req_wmask = 4'h0; if4.resp_ready = 1'b0;
        test_reset();
        test_full_write();
        test_partial_write();
        test_out_of_range();
        test_latency4();
        test_reset_mid_txn();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
